// File: rtl/audio_pair_buffer.sv
// Stereo pair assembler: groups an interleaved L/R sample stream into pairs,
// buffers them, and presents each pair to separate left/right Avalon-ST sinks.

module audio_pair_chan #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              empty,
  input  logic              pop,
  input  logic              mute_q,
  input  logic [DATA_W-1:0] head,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              done
);
  logic taken;
  logic hs;

  assign valid = !empty && !taken;
  assign hs    = valid && ready;
  // done: this channel's half of the head pair is delivered (now or earlier)
  assign done  = taken || hs;
  assign data  = (mute_q || empty) ? '0 : head;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  taken <= 1'b0;
    else if (pop)  taken <= 1'b0;
    else if (hs)   taken <= 1'b1;
  end
endmodule

module audio_pair_buffer #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sop,
  input  logic              mute,
  output logic [DATA_W-1:0] left_data,
  output logic              left_valid,
  input  logic              left_ready,
  output logic [DATA_W-1:0] right_data,
  output logic              right_valid,
  input  logic              right_ready,
  output logic [CNT_W-1:0]  underrun_count,
  output logic              sync_err
);
  localparam int              AW      = $clog2(DEPTH);
  localparam int              NUM_CH  = 2;
  localparam logic [AW:0]     PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {EXPECT_L = 1'b0, EXPECT_R = 1'b1} in_state_t;
  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] l;
  } pair_t;

  in_state_t          state;
  logic [DATA_W-1:0]  hold_l;
  pair_t              mem [DEPTH];
  pair_t              head;
  logic [AW:0]        wr_ptr, rd_ptr;
  logic               full, empty;
  logic               accept, push, pop, resync;
  logic               mute_q, starved, starve_set;

  logic [NUM_CH-1:0][DATA_W-1:0] head_ch, data_ch;
  logic [NUM_CH-1:0]             ready_ch, valid_ch, done_ch;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // No pass-through: a pop in the same cycle does not relieve a full FIFO.
  assign in_ready = (state == EXPECT_L) || !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && (state == EXPECT_R) && !in_sop;
  assign resync   = accept && (state == EXPECT_R) && in_sop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= EXPECT_L;
      hold_l   <= '0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= resync;
      if (accept) begin
        case (state)
          EXPECT_L: begin
            hold_l <= in_data;
            state  <= EXPECT_R;
          end
          EXPECT_R: begin
            // An sop on the right slot means we lost alignment: restart the pair.
            if (in_sop) hold_l <= in_data;
            else        state  <= EXPECT_L;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{r: in_data, l: hold_l};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign head        = mem[rd_ptr[AW-1:0]];
  assign head_ch[0]  = head.l;
  assign head_ch[1]  = head.r;
  assign ready_ch    = {right_ready, left_ready};
  assign pop         = !empty && (&done_ch);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    audio_pair_chan #(.DATA_W(DATA_W)) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .empty   (empty),
      .pop     (pop),
      .mute_q  (mute_q),
      .head    (head_ch[g]),
      .ready   (ready_ch[g]),
      .valid   (valid_ch[g]),
      .data    (data_ch[g]),
      .done    (done_ch[g])
    );
  end

  assign left_valid  = valid_ch[0];
  assign right_valid = valid_ch[1];
  assign left_data   = data_ch[0];
  assign right_data  = data_ch[1];

  // Mute is sampled only between pairs so a pair is never split across mute states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   mute_q <= 1'b0;
    else if (pop || !(|done_ch))    mute_q <= mute;
  end

  assign starve_set = left_ready && empty && !starved;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starved        <= 1'b0;
      underrun_count <= '0;
    end else begin
      if (push)            starved <= 1'b0;
      else if (starve_set) starved <= 1'b1;
      if (starve_set && (underrun_count != '1))
        underrun_count <= underrun_count + CNT_ONE;
    end
  end
endmodule

// File: tb/tb_audio_pair_buffer.sv
// Scoreboard bench for audio_pair_buffer: beat-level pairing model feeds
// per-channel expectation queues, an independent monitor checks every handshake.

module tb_audio_pair_buffer;
  localparam int DATA_W = 24;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [DATA_W-1:0] in_data;
  logic              in_valid, in_ready, in_sop, mute;
  logic [DATA_W-1:0] left_data, right_data;
  logic              left_valid, left_ready, right_valid, right_ready;
  logic [CNT_W-1:0]  underrun_count;
  logic              sync_err;

  always #5 clk = ~clk;

  audio_pair_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
    .mute(mute),
    .left_data(left_data), .left_valid(left_valid), .left_ready(left_ready),
    .right_data(right_data), .right_valid(right_valid), .right_ready(right_ready),
    .underrun_count(underrun_count), .sync_err(sync_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sync_seen = 0;
  logic [DATA_W-1:0] exp_l[$];
  logic [DATA_W-1:0] exp_r[$];
  int sync_q[$];
  logic mdl_half = 1'b0;
  logic [DATA_W-1:0] mdl_hold = '0;
  logic mdl_mute = 1'b0;
  logic rand_rdy = 1'b0;
  logic mon_exp_s;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pairing rules: first beat is left, a non-sop second beat closes the pair,
  // an sop second beat replaces the held left and flags a realignment.
  task automatic model_accept(input logic [DATA_W-1:0] d, input logic sop);
    if (!mdl_half) begin
      mdl_hold = d;
      mdl_half = 1'b1;
    end else if (sop) begin
      mdl_hold = d;
      sync_q.push_back(cyc + 1);
    end else begin
      exp_l.push_back(mdl_mute ? {DATA_W{1'b0}} : mdl_hold);
      exp_r.push_back(mdl_mute ? {DATA_W{1'b0}} : d);
      mdl_half = 1'b0;
    end
  endtask

  task automatic model_clear();
    exp_l.delete();
    exp_r.delete();
    sync_q.delete();
    mdl_half = 1'b0;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic sop);
    bit done = 1'b0;
    in_data = d; in_sop = sop; in_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!mdl_half) check("in_ready_expect_l", in_ready, 1);
      if (in_ready) begin
        model_accept(d, sop);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_sop = 1'b0;
    check("beat_accepted", done, 1);
  endtask

  task automatic send_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    send_beat(l, 1'b1);
    send_beat(r, 1'b0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 1000 && (exp_l.size() + exp_r.size()) != 0; i++) @(posedge clk);
    check("drain", exp_l.size() + exp_r.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_left_taken();
    for (int i = 0; i < 100 && exp_l.size() != 0; i++) @(negedge clk);
    check("left_taken", exp_l.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: every handshake must match the head of its channel queue.
  always @(negedge clk) begin
    if (reset_n) begin
      mon_exp_s = 1'b0;
      if (sync_q.size() != 0 && sync_q[0] == cyc) begin
        mon_exp_s = 1'b1;
        void'(sync_q.pop_front());
      end
      if (sync_err) sync_seen++;
      check("sync_err", sync_err, mon_exp_s);
      if (left_valid && left_ready) begin
        check("left_has_expected", exp_l.size() != 0, 1);
        if (exp_l.size() != 0) check("left_data", left_data, exp_l.pop_front());
      end
      if (right_valid && right_ready) begin
        check("right_has_expected", exp_r.size() != 0, 1);
        if (exp_r.size() != 0) check("right_data", right_data, exp_r.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) begin
        left_ready  = ($urandom_range(0, 3) != 0);
        right_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic run_random(input int n, input logic m);
    logic sop;
    left_ready = 1'b1; right_ready = 1'b1;
    mute = m; mdl_mute = m;
    repeat (3) @(posedge clk);
    #1 rand_rdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      sop = !mdl_half ? logic'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
      send_beat($urandom & 24'hFFFFFF, sop);
    end
    if (mdl_half) send_beat($urandom & 24'hFFFFFF, 1'b0);
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    left_ready = 1'b1; right_ready = 1'b1;
    wait_drain();
    mute = 1'b0; mdl_mute = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0;
    in_data = '0; in_valid = 1'b0; in_sop = 1'b0; mute = 1'b0;
    left_ready = 1'b0; right_ready = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_left_valid", left_valid, 0);
    check("rst_right_valid", right_valid, 0);
    check("rst_left_data", left_data, 0);
    check("rst_right_data", right_data, 0);
    check("rst_underrun", underrun_count, 0);
    check("rst_sync_err", sync_err, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Basic pair and one-cycle latency
    left_ready = 1'b1; right_ready = 1'b1;
    send_beat(24'h000001, 1'b1);
    send_beat(24'h000002, 1'b0);
    check("lat_left_valid", left_valid, 1);
    check("lat_right_valid", right_valid, 1);
    check("lat_left_data", left_data, 24'h000001);
    check("lat_right_data", right_data, 24'h000002);
    @(posedge clk); #1;
    check("lat_popped", left_valid, 0);
    wait_drain();

    // Fill to DEPTH, fifth right stalls until the cycle after the first pop
    left_ready = 1'b0; right_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_pair(24'h100 + i, 24'h200 + i);
    send_beat(24'h000105, 1'b1);
    in_data = 24'h000205; in_sop = 1'b0; in_valid = 1'b1;
    @(negedge clk); check("full_stall", in_ready, 0);
    @(posedge clk); #1 left_ready = 1'b1;
    @(negedge clk); check("full_left_only", in_ready, 0);
    @(posedge clk); #1 right_ready = 1'b1;
    @(negedge clk); check("full_no_passthru", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk); check("full_release", in_ready, 1);
    if (in_ready) model_accept(24'h000205, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_drain();

    // Resync: A, sop B, C -> pair {B, C}, one sync pulse
    s0 = sync_seen;
    send_beat(24'h00000A, 1'b0);
    send_beat(24'h00000B, 1'b1);
    send_beat(24'h00000C, 1'b0);
    wait_drain();
    check("sync_pulse_count", sync_seen - s0, 1);

    // Mute raised mid-pair: current pair unmuted, next pair zero
    left_ready = 1'b0; right_ready = 1'b0;
    send_pair(24'hABCDEF, 24'h123456);
    left_ready = 1'b1;
    wait_left_taken();
    mute = 1'b1;
    repeat (2) @(posedge clk);
    #1 right_ready = 1'b1;
    wait_drain();
    mdl_mute = 1'b1;
    send_pair(24'h777777, 24'h888888);
    wait_drain();
    // Mute lowered mid-pair: current pair stays muted, next unmuted
    left_ready = 1'b0; right_ready = 1'b0;
    send_pair(24'h999999, 24'hAAAAAA);
    left_ready = 1'b1;
    wait_left_taken();
    mute = 1'b0;
    repeat (2) @(posedge clk);
    #1 right_ready = 1'b1;
    wait_drain();
    mdl_mute = 1'b0;
    send_pair(24'hBBBBBB, 24'hCCCCCC);
    wait_drain();

    run_random(150, 1'b0);
    run_random(100, 1'b1);

    // Reset mid-stream with two pairs buffered and a half pair held
    left_ready = 1'b0; right_ready = 1'b0;
    send_pair(24'h010101, 24'h020202);
    send_pair(24'h030303, 24'h040404);
    send_beat(24'h050505, 1'b1);
    @(posedge clk); #3 reset_n = 1'b0;
    model_clear();
    #1;
    check("mid_rst_left_valid", left_valid, 0);
    check("mid_rst_right_valid", right_valid, 0);
    check("mid_rst_left_data", left_data, 0);
    check("mid_rst_right_data", right_data, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_underrun", underrun_count, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    left_ready = 1'b1; right_ready = 1'b1;
    send_beat(24'h0000E1, 1'b0);
    send_beat(24'h0000E2, 1'b0);
    wait_drain();

    // Underrun episodes from a fresh reset, saturating at all-ones
    @(posedge clk); #3 reset_n = 1'b0;
    model_clear();
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); check("underrun_first", underrun_count, 1);
    for (int k = 2; k <= CNT_MAX + 2; k++) begin
      @(posedge clk); #1;
      send_pair($urandom & 24'hFFFFFF, $urandom & 24'hFFFFFF);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("underrun_count", underrun_count, (k > CNT_MAX) ? CNT_MAX : k);
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
